// File: rtl/packet_buffer_reader.sv
// rtl/packet_buffer_reader.sv - credit-based read client streaming packet buffer bytes out
// Issues driver reads only when a FIFO slot is reserved, so returns can never be dropped.
module packet_buffer_reader #(
  parameter int RAM_SIZE     = 4096,
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = 4,
  parameter int LEN_WIDTH    = 12,
  localparam int AW          = $clog2(RAM_SIZE)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [AW-1:0]        start_addr,
  input  logic [LEN_WIDTH-1:0] len,
  output logic                 busy,
  output logic                 done,
  output logic                 ram_readclk,
  output logic [AW-1:0]        ram_raddr,
  input  logic                 ram_outclk,
  input  logic [7:0]           ram_out,
  input  logic                 rdy,
  output logic                 outclk,
  output logic [7:0]           out
);

  localparam int OCC_MAX = (FIFO_DEPTH > READ_LATENCY) ? FIFO_DEPTH : READ_LATENCY + 1;
  localparam int CW      = $clog2(OCC_MAX + 1);
  localparam int PW      = $clog2(FIFO_DEPTH);
  localparam logic [CW:0] DEPTH_C = FIFO_DEPTH[CW:0];

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t               state;
  logic [AW-1:0]        addr;
  logic [LEN_WIDTH-1:0] remaining;
  logic [CW-1:0]        in_flight;
  logic [CW-1:0]        fifo_count;
  logic [PW-1:0]        rd_ptr;
  logic [PW-1:0]        wr_ptr;
  logic [7:0]           mem [FIFO_DEPTH];

  logic                 push;
  logic                 pop;
  logic                 accept;
  logic                 issue;
  logic                 credit_ok;
  logic [CW:0]          occ;
  logic [AW-1:0]        issue_addr;

  // Returns arriving while idle belong to an aborted request and are discarded.
  assign push   = ram_outclk && (state != IDLE);
  assign outclk = busy && (fifo_count != '0) && rdy;
  assign pop    = outclk;
  assign out    = mem[rd_ptr];

  // The slot freed by this cycle's pop can be reserved by this cycle's issue.
  assign occ       = {1'b0, in_flight} + {1'b0, fifo_count} - {{CW{1'b0}}, pop};
  assign credit_ok = occ < DEPTH_C;

  assign accept     = (state == IDLE) && start && (len != '0);
  assign issue      = accept || ((state == READ) && (remaining != '0) && credit_ok);
  assign issue_addr = accept ? start_addr : addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      addr        <= '0;
      remaining   <= '0;
      in_flight   <= '0;
      fifo_count  <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      ram_readclk <= 1'b0;
      ram_raddr   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= 8'h00;
    end else begin
      done        <= 1'b0;
      ram_readclk <= issue;
      if (issue) ram_raddr <= issue_addr;
      in_flight  <= in_flight + CW'(issue) - CW'(push);
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
      if (push) begin
        mem[wr_ptr] <= ram_out;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);

      case (state)
        IDLE: begin
          if (start) begin
            if (len != '0) begin
              addr      <= start_addr + AW'(1);
              remaining <= len - LEN_WIDTH'(1);
              busy      <= 1'b1;
              state     <= (len == LEN_WIDTH'(1)) ? DRAIN : READ;
            end else begin
              done <= 1'b1;
            end
          end
        end
        READ: begin
          if (issue) begin
            addr      <= addr + AW'(1);
            remaining <= remaining - LEN_WIDTH'(1);
            if (remaining == LEN_WIDTH'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          // Finish in the cycle that pops the last byte so done lands right after it.
          if ((in_flight == '0) && !push &&
              ((fifo_count == '0) || ((fifo_count == CW'(1)) && pop))) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_packet_buffer_reader.sv
// tb/tb_packet_buffer_reader.sv - directed self-checking bench for packet_buffer_reader
module tb_packet_buffer_reader;

  localparam int L  = 2;
  localparam int AW = 12;

  logic        clk;
  logic        rst;
  logic        start;
  logic [11:0] start_addr;
  logic [11:0] len;
  logic        busy;
  logic        done;
  logic        ram_readclk;
  logic [11:0] ram_raddr;
  logic        ram_outclk;
  logic [7:0]  ram_out;
  logic        rdy;
  logic        outclk;
  logic [7:0]  out;

  packet_buffer_reader #(
    .RAM_SIZE(4096), .READ_LATENCY(L), .FIFO_DEPTH(4), .LEN_WIDTH(12)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .len(len),
    .busy(busy), .done(done), .ram_readclk(ram_readclk), .ram_raddr(ram_raddr),
    .ram_outclk(ram_outclk), .ram_out(ram_out), .rdy(rdy), .outclk(outclk), .out(out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver model: mem[i] = i & 0xFF, data and strobe appear L cycles after readclk.
  logic       pipe_v [L];
  logic [7:0] pipe_d [L];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < L; i++) pipe_v[i] <= 1'b0;
    end else begin
      pipe_v[0] <= ram_readclk;
      pipe_d[0] <= ram_raddr[7:0];
      for (int i = 1; i < L; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_d[i] <= pipe_d[i-1];
      end
    end
  end
  assign ram_outclk = pipe_v[L-1];
  assign ram_out    = pipe_d[L-1];

  int         cyc = 0;
  int         iss = 0;
  int         outt = 0;
  int         viol = 0;
  int         done_cnt = 0;
  int         n_assert = 0;
  int         n_fail = 0;
  logic [7:0]  got_q [$];
  int          got_cyc [$];
  logic [11:0] raddr_q [$];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (rst) begin
      iss  = 0;
      outt = 0;
    end else begin
      if (ram_readclk) begin
        iss++;
        raddr_q.push_back(ram_raddr);
      end
      if (iss - outt > 4) viol++;
      if (outclk) begin
        got_q.push_back(out);
        got_cyc.push_back(cyc);
        outt++;
      end
      if (done) done_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    got_q.delete();
    got_cyc.delete();
    raddr_q.delete();
    done_cnt = 0;
  endtask

  int s_cyc;
  int d_cyc;

  task automatic start_req(input logic [11:0] a, input logic [11:0] l);
    start      = 1'b1;
    start_addr = a;
    len        = l;
    s_cyc      = cyc;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      step();
      if (done === 1'b1) seen = 1'b1;
    end
    d_cyc = cyc;
    chk(tag, {31'd0, seen}, 32'd1);
  endtask

  task automatic chk_bytes(input string tag, input int n, input logic [7:0] first);
    logic [7:0] e;
    chk({tag, "_count"}, got_q.size(), n);
    e = first;
    for (int i = 0; i < got_q.size() && i < n; i++) begin
      chk(tag, {24'd0, got_q[i]}, {24'd0, e});
      e = e + 8'd1;
    end
  endtask

  initial begin
    int n;
    int dc;
    int mark;
    rst = 1'b1; start = 1'b0; start_addr = '0; len = '0; rdy = 1'b1;
    step(); step();
    rst = 1'b0;
    chk("reset_outputs", {9'd0, busy, done, ram_readclk, ram_raddr, outclk, out}, 32'd0);

    // Basic read
    clear_logs();
    start_req(12'h010, 12'd8);
    wait_done("basic_done");
    chk_bytes("basic_byte", 8, 8'h10);
    if (got_cyc.size() == 8) begin
      chk("basic_first_latency", got_cyc[0] - s_cyc, L + 2);
      chk("basic_consecutive", got_cyc[7] - got_cyc[0], 7);
      chk("basic_done_after_last", d_cyc - got_cyc[7], 1);
    end
    step();
    chk("basic_done_once", done_cnt, 1);
    chk("basic_idle_busy", {31'd0, busy}, 32'd0);

    // Wrap-around
    clear_logs();
    start_req(12'hFFD, 12'd6);
    wait_done("wrap_done");
    chk("wrap_raddr_count", raddr_q.size(), 6);
    for (int i = 0; i < raddr_q.size() && i < 6; i++)
      chk("wrap_raddr", {20'd0, raddr_q[i]}, (32'hFFD + i) & 32'hFFF);
    chk_bytes("wrap_byte", 6, 8'hFD);

    // Backpressure: random rdy, then a long stall
    clear_logs();
    viol = 0;
    start_req(12'h100, 12'd16);
    for (int i = 0; i < 10; i++) begin
      rdy = 1'($urandom_range(0, 1));
      step();
    end
    rdy = 1'b0;
    repeat (5) step();
    mark = raddr_q.size();
    repeat (15) step();
    chk("stall_no_issue", raddr_q.size(), mark);
    chk("stall_credits_full", raddr_q.size() - got_q.size(), 4);
    rdy = 1'b1;
    wait_done("bp_done");
    chk_bytes("bp_byte", 16, 8'h00);
    chk("bp_occupancy", viol, 0);

    // Zero length
    clear_logs();
    start_req(12'h020, 12'd0);
    chk("zero_done", {30'd0, done, busy}, 32'b10);
    step();
    chk("zero_done_pulse", {31'd0, done}, 32'd0);
    chk("zero_no_reads", raddr_q.size(), 0);

    // Start while busy is ignored
    clear_logs();
    start_req(12'h040, 12'd4);
    chk("ign_busy", {31'd0, busy}, 32'd1);
    start_req(12'h080, 12'd5);
    wait_done("ign_done");
    repeat (10) step();
    chk_bytes("ign_byte", 4, 8'h40);
    chk("ign_reads", raddr_q.size(), 4);
    chk("ign_idle", {31'd0, busy}, 32'd0);

    // Back-to-back: second start in the done cycle
    clear_logs();
    start_req(12'h050, 12'd3);
    wait_done("b2b_done1");
    start = 1'b1; start_addr = 12'h060; len = 12'd3;
    step();
    start = 1'b0;
    chk("b2b_accept", {31'd0, busy}, 32'd1);
    wait_done("b2b_done2");
    step();
    chk("b2b_done_cnt", done_cnt, 2);
    chk("b2b_count", got_q.size(), 6);
    for (int i = 0; i < got_q.size() && i < 6; i++)
      chk("b2b_byte", {24'd0, got_q[i]}, (i < 3) ? 32'h50 + i : 32'h60 + i - 3);

    // Reset mid-operation
    clear_logs();
    start_req(12'h070, 12'd10);
    for (int i = 0; i < 100 && got_q.size() < 5; i++) step();
    chk("rst_mid_reached", {31'd0, got_q.size() >= 5}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid_outputs", {9'd0, busy, done, ram_readclk, ram_raddr, outclk, out}, 32'd0);
    n  = got_q.size();
    dc = done_cnt;
    repeat (10) step();
    chk("rst_mid_no_out", got_q.size(), n);
    chk("rst_mid_no_done", done_cnt, dc);
    chk_bytes("rst_mid_byte", n, 8'h70);
    clear_logs();
    start_req(12'h0A0, 12'd2);
    wait_done("post_rst_done");
    chk_bytes("post_rst_byte", 2, 8'hA0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
